// File: rtl/pool_window_unit.sv
// Per-lane max-pooling datapath. Consumes a raster-ordered pixel stream and
// emits one signed maximum per non-overlapping pool_horiz x pool_vert window,
// tagged with the raster index of that window in the pooled output image.
// Horizontal partial maxima live in hmax; vertical partial maxima for each
// output column live in a small column buffer indexed by the output column.
module pool_window_unit #(
  parameter int DATA_W  = 16,
  parameter int MAX_WID = 64,
  parameter int WIN_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     line_reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [15:0]              row_length,
  input  logic [WIN_W-1:0]         pool_horiz,
  input  logic [WIN_W-1:0]         pool_vert,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [15:0]              out_idx,
  output logic                     cfg_err
);

  localparam int AW = (MAX_WID > 1) ? $clog2(MAX_WID) : 1;

  // Shadow configuration, frozen outside line_reset.
  logic [15:0]      rl_q;
  logic [WIN_W-1:0] ph_q;
  logic [WIN_W-1:0] pv_q;

  // Position counters. Absolute row position is not needed: only the row
  // phase inside the vertical window (v) affects the result.
  logic [15:0]      col;
  logic [WIN_W-1:0] h;
  logic [WIN_W-1:0] v;
  logic [15:0]      ox;
  logic [15:0]      out_cnt;

  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] colbuf [MAX_WID];

  logic                     cfg_bad;
  logic                     accept;
  logic                     usable;
  logic                     col_last;
  logic                     h_last;
  logic                     v_last;
  logic                     cb_we;
  logic                     win_done;
  logic [AW-1:0]            ox_a;
  logic [16:0]              win_end;
  logic signed [DATA_W-1:0] cb_rdata;
  logic signed [DATA_W-1:0] w;
  logic signed [DATA_W-1:0] cm;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign cfg_bad = (ph_q == '0) || (pv_q == '0) || (rl_q == '0) ||
                   (rl_q > 16'(MAX_WID)) || (rl_q < 16'(ph_q));

  assign accept   = in_valid && !line_reset && !cfg_bad;
  assign col_last = (col == rl_q - 16'd1);
  assign h_last   = (h == ph_q - WIN_W'(1));
  assign v_last   = (v == pv_q - WIN_W'(1));

  // col - h is the first column of the current window (ox*ph), so the window
  // is usable exactly when it ends at or before the row end. This is the same
  // test as col < floor(rl/ph)*ph without needing a divider.
  assign win_end  = 17'(col) - 17'(h) + 17'(ph_q);
  assign usable   = (win_end <= 17'(rl_q));

  assign ox_a     = ox[AW-1:0];
  // Asynchronous read: an entry written on one edge is already visible the
  // following cycle, so back-to-back writes to one entry (ph==1, one output
  // column) see write-first data without a separate bypass path.
  assign cb_rdata = colbuf[ox_a];

  assign cb_we    = accept && usable && h_last;
  assign win_done = cb_we && v_last;

  // Window maxima for the current beat: horizontal running max, then the
  // column-wise merge with rows already folded into the column buffer.
  // NOTE: every always_comb output gets a value on all paths (directly or via
  // a default first), otherwise synthesis infers a latch.
  always_comb begin
    w  = (h == '0) ? in_data : smax(hmax, in_data);
    cm = (v == '0) ? w : smax(cb_rdata, w);
  end

  // Shadow config capture, position counters, running max and output stage.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rl_q      <= '0;
      ph_q      <= '0;
      pv_q      <= '0;
      col       <= '0;
      h         <= '0;
      v         <= '0;
      ox        <= '0;
      out_cnt   <= '0;
      hmax      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (line_reset) begin
      rl_q      <= row_length;
      ph_q      <= pool_horiz;
      pv_q      <= pool_vert;
      col       <= '0;
      h         <= '0;
      v         <= '0;
      ox        <= '0;
      out_cnt   <= '0;
      hmax      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          h   <= '0;
          ox  <= '0;
          v   <= v_last ? '0 : v + WIN_W'(1);
        end else begin
          col <= col + 16'd1;
          if (h_last) begin
            h  <= '0;
            ox <= ox + 16'd1;
          end else begin
            h  <= h + WIN_W'(1);
          end
        end
        if (usable) begin
          hmax <= w;
        end
        if (win_done) begin
          out_valid <= 1'b1;
          out_data  <= cm;
          out_idx   <= out_cnt;
          out_cnt   <= out_cnt + 16'd1;
        end
      end
    end
  end

  // Column partial-max buffer.
  // NOTE: the buffer has no reset; each entry is written with v==0 data
  // before any read that uses it, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (cb_we) begin
      colbuf[ox_a] <= cm;
    end
  end

  // Config legality flag, registered from the shadow config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_bad;
    end
  end

endmodule
